signed_seq_divider: RTL and testbench

Sequential signed radix-2 restoring divider: the inverse counterpart of the shift-and-add signed multiplier datapath. It accepts a signed dividend/divisor pair over a valid/ready handshake and computes quotient and remainder over WIDTH iterations. It returns the result over a second valid/ready handshake. Results match Verilog signed `/` and `%`: truncation toward zero, and the remainder takes the sign of the dividend.

---
 rtl/signed_seq_divider.sv | 126 ++++++++++++
 tb/tb_signed_seq_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_seq_divider.sv
// Signed restoring divider, one quotient bit per cycle; out_valid appears WIDTH+2 edges after accept, counting the accept edge.
// Blocking: one operation in flight; results hold in DONE until out_ready. Optional flags under `DIV_FLAGS_EN`.
module signed_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_FLAGS_EN
    ,
    output logic             div_by_zero,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             accept;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;
    logic             q_bit;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);

    // A borrow out of the top bit means the partial remainder was below the divisor.
    assign part  = {rem, acc[WIDTH-1]};
    assign diff  = part - {1'b0, div_mag};
    assign q_bit = ~diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            div_mag   <= '0;
            rem       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                acc     <= mag(dividend);
                div_mag <= mag(divisor);
                rem     <= '0;
                cnt     <= CNT_INIT;
                q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg   <= dividend[WIDTH-1];
            end
            if (state == CALC) begin
                rem <= q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                acc <= {acc[WIDTH-2:0], q_bit};
                cnt <= cnt - CNT_ONE;
            end
            if (state == FIX) begin
                quotient  <= q_neg ? ('0 - acc) : acc;
                remainder <= r_neg ? ('0 - rem) : rem;
            end
        end
    end

`ifdef DIV_FLAGS_EN
    logic ovf_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                ovf_pend    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
            if (state == FIX) begin
                div_by_zero <= (div_mag == '0);
                overflow    <= ovf_pend;
            end
        end
    end
`endif

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed and swept checks of signed_seq_divider (WIDTH = 8) against a plain signed / and % model.
module tb_signed_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [7:0] remainder;
`ifdef DIV_FLAGS_EN
    logic       div_by_zero;
    logic       overflow;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_r[$];
    logic       exp_dz[$];
    logic       exp_ov[$];

    signed_seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
`ifdef DIV_FLAGS_EN
        , .div_by_zero(div_by_zero), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic checki(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Truncating signed division; x/0 gives the documented sign-only quotient and remainder = x.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = (bi == 0);
        ov = (ai == -128) && (bi == -1);
        if (bi == 0) begin
            q = (ai < 0) ? 8'd1 : 8'hFF;
            r = a;
        end else begin
            q = 8'(ai / bi);
            r = 8'(ai % bi);
        end
    endfunction

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        logic dz, ov;
        model(a, b, q, r, dz, ov);
        exp_q.push_back(q);
        exp_r.push_back(r);
        exp_dz.push_back(dz);
        exp_ov.push_back(ov);
    endtask

    task automatic pin(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic dz, input logic ov);
        logic [7:0] mq, mr;
        logic mdz, mov;
        model(a, b, mq, mr, mdz, mov);
        check8("model_q", mq, q);
        check8("model_r", mr, r);
        checki("model_dz", int'(mdz), int'(dz));
        checki("model_ov", int'(mov), int'(ov));
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checki("unexpected_result", 1, 0);
            end else begin
                check8("quotient", quotient, exp_q[0]);
                check8("remainder", remainder, exp_r[0]);
`ifdef DIV_FLAGS_EN
                checki("div_by_zero", int'(div_by_zero), int'(exp_dz[0]));
                checki("overflow", int'(overflow), int'(exp_ov[0]));
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(exp_r.pop_front());
            void'(exp_dz.pop_front());
            void'(exp_ov.pop_front());
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checki("timeout_in_ready", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit noise);
        bit ok;
        int lat;
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        wait_ready(ok);
        if (!ok) return;
        @(posedge clk);
        push(a, b);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = a;
        lat = 0;
        ok  = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            #2;
            if (noise) begin
                in_valid = 1'b1;
                dividend = 8'($urandom_range(0, 255));
                divisor  = 8'($urandom_range(0, 255));
            end
        end
        if (!ok) begin
            checki("timeout_out_valid", 0, 1);
            return;
        end
        checki("latency_edges", lat, 10);
        #2;
        in_valid = 1'b0;
        repeat (hold) @(negedge clk);
        if (hold > 0) checki("hold_out_valid", int'(out_valid), 1);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        longint t_prev;
        logic [7:0] a, b;

        #12;
        checki("reset_in_ready", int'(in_ready), 1);
        checki("reset_out_valid", int'(out_valid), 0);
        check8("reset_quotient", quotient, 8'd0);
        check8("reset_remainder", remainder, 8'd0);
`ifdef DIV_FLAGS_EN
        checki("reset_div_by_zero", int'(div_by_zero), 0);
        checki("reset_overflow", int'(overflow), 0);
`endif
        rst_n = 1'b1;

        pin(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        pin(-8'sd100, 8'd7, -8'sd14, -8'sd2, 1'b0, 1'b0);
        pin(8'd100, -8'sd7, -8'sd14, 8'd2, 1'b0, 1'b0);
        pin(-8'sd100, -8'sd7, 8'd14, -8'sd2, 1'b0, 1'b0);
        pin(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 1'b1);
        pin(8'h80, 8'd1, 8'h80, 8'd0, 1'b0, 1'b0);
        pin(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        pin(-8'sd5, 8'd0, 8'd1, -8'sd5, 1'b1, 1'b0);
        pin(8'd127, 8'd3, 8'd42, 8'd1, 1'b0, 1'b0);

        run_op(8'd100, 8'd7, 0, 1'b0);
        run_op(-8'sd100, 8'd7, 0, 1'b0);
        run_op(8'd100, -8'sd7, 0, 1'b1);
        run_op(-8'sd100, -8'sd7, 0, 1'b0);
        run_op(8'h80, 8'hFF, 0, 1'b0);
        run_op(8'h80, 8'd1, 0, 1'b0);
        run_op(8'd5, 8'd0, 20, 1'b1);
        run_op(-8'sd5, 8'd0, 0, 1'b0);
        run_op(8'd127, 8'h80, 3, 1'b0);
        run_op(8'h80, 8'h80, 0, 1'b0);

        // Back-to-back with out_ready held high: accepts land every 11 cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd9;
        in_valid  = 1'b1;
        t_prev    = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ready(ok);
            if (!ok) break;
            @(posedge clk);
            push(dividend, divisor);
            if (k > 0) checki("b2b_interval", int'(($time - t_prev) / 10), 11);
            t_prev = $time;
            #1;
            dividend = 8'($urandom_range(0, 255));
            divisor  = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(posedge clk);
        checki("b2b_drained", exp_q.size(), 0);
        #1;
        out_ready = 1'b0;

        // Reset during the fourth CALC cycle aborts the operation.
        @(posedge clk);
        #1;
        dividend = 8'd50;
        divisor  = 8'd3;
        in_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checki("abort_in_ready", int'(in_ready), 1);
        checki("abort_out_valid", int'(out_valid), 0);
        check8("abort_quotient", quotient, 8'd0);
        #3;
        rst_n = 1'b1;
        run_op(8'd127, 8'd3, 0, 1'b0);

        for (int k = 0; k < 1500; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (k % 16 == 0) a = 8'h80;
            if (k % 7 == 0) b = 8'hFF;
            else if (k % 11 == 0) b = 8'd0;
            run_op(a, b, k % 5 == 0 ? 2 : 0, k % 3 == 0);
        end

        checki("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
